hamming_tx_serial: RTL

Transmit side of the Hamming(15,11) link. Accepts 11-bit data words over a valid/ready handshake and encodes each into a 15-bit codeword using the same bit map as the team's corrector. It then serializes the codeword onto a single UART-style line: start bit, 15 code bits (index 0 first), stop bit. An optional per-word single-bit error injection exercises the receiver/corrector path.

---
 rtl/hamming_tx_serial.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hamming_tx_serial.sv
// Hamming(15,11) encoder with a one-word input buffer and a UART-style serializer.
// Frame: start bit (0), codeword indices 0..14 LSB first, stop bit (1).
module hamming_tx_serial #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] in_data,
  input  logic [3:0]  in_err_pos,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy,
  output logic [14:0] cw_out,
  output logic        cw_load
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_div;
  logic [3:0]  r_bit;
  logic [14:0] r_shift;
  logic [14:0] r_buf;
  logic        r_buf_full;
  logic        r_tx;
  logic        r_cw_load;
  logic [14:0] r_cw_out;

  logic        w_tick;
  logic        w_load;
  logic        w_accept;
  logic [14:0] w_cw;

  // Index 0..14 holds Hamming position 1..15; parities sit at positions 1,2,4,8.
  function automatic logic [14:0] encode(input logic [10:0] d, input logic [3:0] err);
    logic [14:0] c;
    c       = '0;
    c[2]    = d[0];
    c[4]    = d[1];
    c[5]    = d[2];
    c[6]    = d[3];
    c[14:8] = d[10:4];
    c[0]    = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
    c[1]    = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
    c[3]    = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    c[7]    = ^c[14:8];
    if (err != 4'd0) begin
      c = c ^ (15'd1 << (err - 4'd1));
    end
    return c;
  endfunction

  assign w_cw     = encode(in_data, in_err_pos);
  assign w_accept = in_valid && !r_buf_full;
  assign w_tick   = (r_div == DIV_LAST);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_buf_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_tick && r_bit == 4'd14) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_buf_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_buf_full <= 1'b0;
      r_tx       <= 1'b1;
      r_cw_load  <= 1'b0;
      r_cw_out   <= '0;
    end else begin
      r_cw_load <= w_load;

      // Accept needs an empty buffer and load needs a full one, so they never collide.
      if (w_accept)    r_buf_full <= 1'b1;
      else if (w_load) r_buf_full <= 1'b0;

      if (w_load) begin
        r_shift  <= r_buf;
        r_cw_out <= r_buf;
      end else if (r_state == S_DATA && w_tick) begin
        r_shift <= r_shift >> 1;
      end

      if (r_state == S_IDLE || w_tick) r_div <= '0;
      else                             r_div <= r_div + 16'd1;

      if (r_state != S_DATA || (w_tick && r_bit == 4'd14)) r_bit <= '0;
      else if (w_tick)                                       r_bit <= r_bit + 4'd1;

      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
    end
  end

  // NOTE: the buffer payload needs no reset; r_buf_full alone says whether it holds a word.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf <= w_cw;
  end

  assign in_ready = !r_buf_full;
  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE);
  assign cw_out   = r_cw_out;
  assign cw_load  = r_cw_load;

endmodule
